// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with mid-bit sampling, a 2-flop
// input synchronizer and a single-entry valid/ready holding register that
// reports framing errors and overruns as one-cycle status pulses.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV  = CLK_FREQ / UART_BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          rx_m, rx_s;
    logic          byte_done;
    logic          ferr_set;

    // Two-flop synchronizer for the asynchronous pad; idles high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // FSM state, baud counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // Next-state logic; every transition clears the baud counter.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        byte_done = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == DIV_M1) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == DIV_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = BRK_WAIT;
                    end
                end
            end
            BRK_WAIT: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Holding register with simultaneous pop/load, plus status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= byte_done && rx_valid && !rx_ready;
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at a shortened bit time
// (50 MHz / 460800 baud -> DIV=108, HALF=54) with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned DIV   = 108;
    localparam int unsigned HALF  = 54;
    localparam int unsigned FRAME = 10 * DIV;
    // Pad edge to rx_valid: 2 sync flops + IDLE detect, then HALF + 9*DIV.
    localparam int unsigned LAT   = 3 + HALF + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int unsigned n_assert = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    int unsigned n_vrise = 0, vrise_cyc = 0, run = 0, last_run = 0;
    int unsigned n_ferr = 0, n_ferr_cyc = 0;
    int unsigned n_ovr = 0, n_ovr_cyc = 0, ovr_cyc = 0;
    logic        v_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
    logic [7:0]  popped[$];

    uart_rx #(.CLK_FREQ(50_000_000), .UART_BAUD(460_800)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: edges, pulse widths and popped bytes.
    always @(negedge clk) begin
        if (rx_valid && !v_prev) begin
            n_vrise   <= n_vrise + 1;
            vrise_cyc <= cyc;
        end
        if (rx_valid) run <= v_prev ? run + 1 : 1;
        else if (v_prev) last_run <= run;
        if (rx_valid && rx_ready) popped.push_back(rx_data);
        if (frame_err) n_ferr_cyc <= n_ferr_cyc + 1;
        if (frame_err && !fe_prev) n_ferr <= n_ferr + 1;
        if (overrun) n_ovr_cyc <= n_ovr_cyc + 1;
        if (overrun && !ov_prev) begin
            n_ovr   <= n_ovr + 1;
            ovr_cyc <= cyc;
        end
        v_prev  <= rx_valid;
        fe_prev <= frame_err;
        ov_prev <= overrun;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller must be aligned 1 ns after a rising edge; stays aligned on return.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int unsigned c0);
        c0 = cyc;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop_bit;
        tick(DIV);
    endtask

    logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    initial begin
        int unsigned c0, c1, b_vr, b_fe, b_fec, b_ov, b_ovc, b_pop, lat;

        // Reset state
        tick(3);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(5);

        // 1: single byte 0x48 with rx_ready held high
        rx_ready = 1'b1;
        b_vr = n_vrise; b_fe = n_ferr; b_ov = n_ovr; b_pop = popped.size();
        send_frame(8'h48, 1'b1, c0);
        tick(3);
        check("t1_valid_rises", n_vrise - b_vr, 1);
        check("t1_valid_width", last_run, 1);
        lat = vrise_cyc - c0;
        check("t1_latency_window", (lat >= LAT - 2 && lat <= LAT + 2), 1);
        check("t1_byte_count", popped.size() - b_pop, 1);
        check("t1_byte", popped[popped.size() - 1], 8'h48);
        check("t1_no_ferr", n_ferr - b_fe, 0);
        check("t1_no_ovr", n_ovr - b_ov, 0);

        // 2: short low glitch is rejected, then 0x55
        b_vr = n_vrise; b_fe = n_ferr;
        c0 = cyc;
        rx = 1'b0;
        tick(20);
        check("t2_busy_during_glitch", busy, 1);
        rx = 1'b1;
        while (busy && (cyc - c0) < 4 * DIV) tick(1);
        check("t2_busy_cleared", busy, 0);
        check("t2_busy_bound", ((cyc - c0) <= HALF + 3), 1);
        tick(DIV);
        check("t2_no_valid", n_vrise - b_vr, 0);
        check("t2_no_ferr", n_ferr - b_fe, 0);
        send_frame(8'h55, 1'b1, c0);
        tick(3);
        check("t2_byte", popped[popped.size() - 1], 8'h55);

        // 3: framing error then held break, then 0x3C
        b_vr = n_vrise; b_fe = n_ferr; b_fec = n_ferr_cyc;
        send_frame(8'hA5, 1'b0, c0);
        tick(3 * DIV);
        check("t3_busy_in_break", busy, 1);
        check("t3_ferr_pulses", n_ferr - b_fe, 1);
        rx = 1'b1;
        tick(10);
        check("t3_busy_after_break", busy, 0);
        check("t3_ferr_width", n_ferr_cyc - b_fec, 1);
        check("t3_no_valid", n_vrise - b_vr, 0);
        tick(DIV);
        send_frame(8'h3C, 1'b1, c0);
        tick(3);
        check("t3_byte", popped[popped.size() - 1], 8'h3C);

        // 4: overrun with rx_ready low, back-to-back 0x11, 0x22
        rx_ready = 1'b0;
        b_ov = n_ovr; b_ovc = n_ovr_cyc;
        send_frame(8'h11, 1'b1, c0);
        send_frame(8'h22, 1'b1, c1);
        tick(3);
        check("t4_valid", rx_valid, 1);
        check("t4_data_kept", rx_data, 8'h11);
        check("t4_ovr_pulses", n_ovr - b_ov, 1);
        check("t4_ovr_width", n_ovr_cyc - b_ovc, 1);
        lat = ovr_cyc - c1;
        check("t4_ovr_timing", (lat >= LAT - 2 && lat <= LAT + 2), 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        check("t4_pop_valid", rx_valid, 0);
        check("t4_pop_data_held", rx_data, 8'h11);
        tick(DIV);

        // 5: 13-byte stream, rx_ready only on each completion cycle
        b_vr = n_vrise; b_fe = n_ferr; b_ov = n_ovr; b_pop = popped.size();
        c0 = cyc;
        fork
            begin
                for (int i = 0; i < 13; i++) send_frame(msg[i], 1'b1, c1);
            end
            begin
                for (int i = 0; i < 13; i++) begin
                    while (cyc != c0 + i * FRAME + LAT - 1) tick(1);
                    rx_ready = 1'b1;
                    tick(1);
                    rx_ready = 1'b0;
                end
            end
        join
        tick(3);
        check("t5_valid_stays_high", n_vrise - b_vr, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(2);
        check("t5_byte_count", popped.size() - b_pop, 13);
        for (int i = 0; i < 13; i++) begin
            if (popped.size() > b_pop + i)
                check($sformatf("t5_byte%0d", i), popped[b_pop + i], msg[i]);
        end
        check("t5_no_ovr", n_ovr - b_ov, 0);
        check("t5_no_ferr", n_ferr - b_fe, 0);
        tick(DIV);

        // 6: asynchronous reset during data bit 3 of 0xFF, then 0x7E
        send_frame(8'h5A, 1'b1, c0);
        tick(3);
        check("t6_pre_valid", rx_valid, 1);
        check("t6_pre_data", rx_data, 8'h5A);
        rx = 1'b0;
        tick(DIV);
        rx = 1'b1;
        tick(3 * DIV + DIV / 2);
        check("t6_busy_mid_frame", busy, 1);
        #5 rst_n = 1'b0;
        #1;
        check("t6_rst_rx_data", rx_data, 8'h00);
        check("t6_rst_rx_valid", rx_valid, 0);
        check("t6_rst_frame_err", frame_err, 0);
        check("t6_rst_overrun", overrun, 0);
        check("t6_rst_busy", busy, 0);
        tick(4);
        rst_n = 1'b1;
        tick(DIV);
        b_vr = n_vrise;
        rx_ready = 1'b1;
        send_frame(8'h7E, 1'b1, c0);
        tick(3);
        check("t6_valid_rises", n_vrise - b_vr, 1);
        check("t6_byte", popped[popped.size() - 1], 8'h7E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the SoC peripheral bus. It is the receive counterpart of the SoC UART transmit path and samples the `uart_rx` pad line. The frame format is 8N1, LSB first. A frame is sampled at mid-bit from a baud-rate divider clocked by the 50 MHz system clock. Each received byte is delivered through a single-entry valid/ready holding register, with framing-error and overrun status pulses. It sits between the top-level `uart_rx` pin and the UART register interface.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BAUD, 115200, line baud rate.
- DIV (derived, localparam), CLK_FREQ/UART_BAUD truncated (434 at defaults), clock cycles per bit.
- HALF (derived, localparam), DIV/2 truncated (217), cycles from start-bit edge to start-bit centre.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line from pad; asynchronous; idles high.
- rx_data  out  8  received byte; valid while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts the byte when rx_valid&&rx_ready at a rising clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: byte completed while the holding register was full and not being popped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - sync flops=1, state=IDLE, counters=0, shift register=0.
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Applies immediately, including mid-frame. Any partial byte is discarded.
- Synchronizer: 2-flop, reset to 1. All FSM logic uses the synchronized rx_s, so there are 2 cycles of latency from the pad.
- Baud counter: 0..DIV-1. It clears on every state entry. The "tick" fires when the counter equals the state's target, then the counter clears.
- FSM states:
  - IDLE: when rx_s==0, go to START with counter=0.
  - START: at counter==HALF-1, sample rx_s.
    - rx_s==0: go to DATA with bit_idx=0.
    - rx_s==1: go to IDLE (glitch rejected; no status pulse).
  - DATA: at counter==DIV-1, shift rx_s in at the MSB (shift right), giving LSB-first assembly, and increment bit_idx (3 bits). After the 8th sample go to STOP.
  - STOP: at counter==DIV-1, sample rx_s.
    - 1: byte complete, go to IDLE.
    - 0: pulse frame_err, discard the byte, go to BRK_WAIT.
  - BRK_WAIT: stay until rx_s==1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err and no spurious frames.
- Byte completion, evaluated in the same cycle as the stop sample:
  - rx_valid=0: load rx_data; rx_valid=1 on the next cycle.
  - rx_valid=1 and rx_ready=1: pop and load in the same edge. rx_valid stays 1, rx_data takes the new byte, no overrun.
  - rx_valid=1 and rx_ready=0: pulse overrun, drop the new byte, keep the old rx_data.
- Pop without completion: rx_valid&&rx_ready clears rx_valid next cycle. rx_data holds its last value.
- Sample timing: the k-th data bit is sampled HALF+(k+1)·DIV cycles after START entry, k=0..7. The stop bit is sampled at HALF+9·DIV.
- Timing tolerance: rx_valid rises 4124–4128 clk after the pad falling edge at defaults. Pulses are exactly 1 cycle wide.
- Back-to-back frames: the FSM returns to IDLE at stop-bit centre. A start edge arriving half a bit later is detected, so there is no minimum inter-frame gap beyond the 1 stop bit.
- rx_ready is ignored while rx_valid=0.

Test Plan:
1. Single byte: defaults, rx_ready=1, send 0x48 at 8680 ns/bit → rx_valid high for exactly 1 cycle, rx_data=0x48, 4124–4128 cycles after the start edge; frame_err=overrun=0.
2. Glitch rejection: rx low for 100 cycles, then high → no rx_valid, busy returns to 0 within HALF+3 cycles. A following 0x55 frame is received as 0x55.
3. Framing/break: send 0xA5 with the stop bit 0 and the line held low 3 bit times, then high → one frame_err pulse, no rx_valid, busy=1 until the line goes high. A next frame 0x3C is received correctly.
4. Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back → rx_valid=1 with rx_data=0x11, and one overrun pulse at the second stop centre. rx_data stays 0x11. Raising rx_ready for 1 cycle clears rx_valid.
5. Stream with simultaneous pop/load: send "Hello World!\n" (13 bytes, no gaps) with rx_ready asserted only on the cycle a completion occurs → 13 bytes captured in order (0x48…0x0A), no overrun, no frame_err.
6. Reset mid-frame: assert rst_n=0 during data bit 3 of 0xFF → all outputs return to their reset values asynchronously. After release with the line idle, 0x7E is received as 0x7E.
